traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Parametrised traffic-light sequencer. Drives N_PHASES conflicting approaches in round-robin order.
//   Has an integrated tick-driven interval counter, so no external timer handshake is needed.
//   Adds bounded sensor-driven green extension, an all-red clearance interval, and a latched pedestrian walk interval.
//   Timing is runtime-reprogrammable. Sits between the timebase divider and the lamp/LED driver.
// PARAMETERS
//   N_PHASES  2  number of approaches (2..8)
//   CNT_W     8  width of interval counter and time inputs
//   BASE_T    6  reset default base green time, in ticks
//   EXT_T     3  reset default extension time, in ticks
//   YEL_T     2  reset default yellow time, in ticks
//   ALLRED_T  1  all-red clearance time, in ticks (fixed)
//   WALK_T    4  walk interval, in ticks (fixed)
//   MAX_EXT   2  max extensions granted per green (0 = never extend)
//   WALK_PH   0  phase whose yellow is followed by the walk interval
// PORTS
//   clk           in   1         system clock, rising edge
//   globalReset   in   1         asynchronous, active-high reset
//   tick          in   1         1-cycle timebase strobe; counter moves only when high
//   reprogramInp  in   1         sync; load time inputs and restart sequence
//   baseTime      in   CNT_W     new base green time (sampled on reprogramInp)
//   extTime       in   CNT_W     new extension time (sampled on reprogramInp)
//   yelTime       in   CNT_W     new yellow time (sampled on reprogramInp)
//   sensorInput   in   N_PHASES  vehicle present, one bit per phase
//   walkReq       in   1         pedestrian request, any length >= 1 cycle
//   greenOut      out  N_PHASES  one-hot green lamps
//   yellowOut     out  N_PHASES  one-hot yellow lamps
//   redOut        out  N_PHASES  red lamps = ~(green|yellow)
//   walkOut       out  1         walk lamp
//   walkPending   out  1         walk request latched, not yet served
//   phaseIdx      out  $clog2(N_PHASES)  current phase
// BEHAVIOUR
//   States: GRN_BASE, GRN_EXT, YEL, ALL_RED, WALK.
//     All outputs are registered and decoded from state and phaseIdx.
//   Reset (async):
//     state=GRN_BASE, phaseIdx=0, remain=BASE_T, extCnt=0.
//     Time registers = BASE_T/EXT_T/YEL_T; walkPending=0.
//     greenOut=1<<0, yellowOut=0, redOut=~1, walkOut=0.
//   Timing:
//     On state entry, remain is loaded with T (0 is treated as 1).
//     Each tick decrements remain. A tick with remain==1 expires the state.
//     The next state and outputs appear on that same clock edge, so every state lasts exactly T ticks.
//   Transitions on expiry:
//     GRN_BASE/GRN_EXT -> GRN_EXT (load ext time, extCnt++)
//       if sensorInput[phaseIdx] && extCnt<MAX_EXT; else -> YEL.
//     YEL -> WALK if phaseIdx==WALK_PH && walkPending; else -> ALL_RED.
//     WALK -> ALL_RED.
//     ALL_RED -> GRN_BASE of phaseIdx+1, wrapping N_PHASES-1 -> 0; extCnt cleared.
//   The sensor is sampled only on the expiry cycle; later changes do not cut the current interval short.
//   Walk latch:
//     Set by walkReq. Cleared on entry to WALK.
//     A walkReq in the entry cycle is absorbed (latch ends at 0).
//     WALK drives all red + walkOut=1.
//   reprogramInp:
//     Beats tick and every expiry. Loads the three time inputs.
//     Next edge: GRN_BASE, phaseIdx=0, remain=new baseTime, extCnt=0. walkPending is kept.
//   Reset mid-operation: immediate return to reset values, no clock needed.
//   Never more than one green or yellow asserted. Green and yellow are never both on in any phase.
// TESTING
//   T1 defaults, no sensors, 1 tick/4 clks:
//     green[0] 6 ticks -> yellow[0] 2 -> all red 1 -> green[1] 6 -> ... -> green[0].
//   T2 sensorInput[0]=1 held:
//     green[0] lasts 6+3+3=12 ticks, then yellow[0] even though the sensor is still high.
//   T3 1-clk walkReq during green[1]:
//     walkPending=1 until yellow[0] ends -> walkOut 4 ticks, all red -> all red 1 -> green[1]; walkPending=0.
//   T4 reprogramInp with baseTime=10, yelTime=0 during YEL of phase 1, tick same cycle:
//     next edge green[0]; lasts 10 ticks; yellow lasts 1 tick.
//   T5 globalReset pulsed between edges during WALK:
//     outputs go to reset values before the next edge; walkPending=0.
//   T6 N_PHASES=3:
//     order 0->1->2->0; one-hot, no-overlap assertion checked every cycle.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Round-robin traffic-light sequencer with a tick-driven interval counter, bounded sensor
// extension, all-red clearance and a latched pedestrian walk interval.
module traffic_phase_sequencer #(
  parameter int unsigned N_PHASES = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned BASE_T   = 6,
  parameter int unsigned EXT_T    = 3,
  parameter int unsigned YEL_T    = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 4,
  parameter int unsigned MAX_EXT  = 2,
  parameter int unsigned WALK_PH  = 0
) (
  input  logic                        clk,
  input  logic                        globalReset,
  input  logic                        tick,
  input  logic                        reprogramInp,
  input  logic [CNT_W-1:0]            baseTime,
  input  logic [CNT_W-1:0]            extTime,
  input  logic [CNT_W-1:0]            yelTime,
  input  logic [N_PHASES-1:0]         sensorInput,
  input  logic                        walkReq,
  output logic [N_PHASES-1:0]         greenOut,
  output logic [N_PHASES-1:0]         yellowOut,
  output logic [N_PHASES-1:0]         redOut,
  output logic                        walkOut,
  output logic                        walkPending,
  output logic [$clog2(N_PHASES)-1:0] phaseIdx
);

  localparam int unsigned PhW  = $clog2(N_PHASES);
  localparam int unsigned ExtW = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  typedef enum logic [2:0] {
    StGrnBase,
    StGrnExt,
    StYel,
    StAllRed,
    StWalk
  } state_e;

  state_e                state_q, state_d;
  logic [PhW-1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic [ExtW-1:0]       ext_cnt_q, ext_cnt_d;
  logic [CNT_W-1:0]      base_t_q, base_t_d;
  logic [CNT_W-1:0]      ext_t_q, ext_t_d;
  logic [CNT_W-1:0]      yel_t_q, yel_t_d;
  logic                  pend_q, pend_d;
  logic [N_PHASES-1:0]   green_q, green_d;
  logic [N_PHASES-1:0]   yellow_q, yellow_d;
  logic [N_PHASES-1:0]   red_q, red_d;
  logic                  walk_q, walk_d;

  // A programmed time of zero still occupies one tick.
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    ext_cnt_d = ext_cnt_q;
    base_t_d  = base_t_q;
    ext_t_d   = ext_t_q;
    yel_t_d   = yel_t_q;
    pend_d    = pend_q | walkReq;

    if (reprogramInp) begin
      base_t_d  = baseTime;
      ext_t_d   = extTime;
      yel_t_d   = yelTime;
      state_d   = StGrnBase;
      phase_d   = '0;
      remain_d  = nz(baseTime);
      ext_cnt_d = '0;
    end else if (tick) begin
      if (remain_q <= CNT_W'(1)) begin
        unique case (state_q)
          StGrnBase, StGrnExt: begin
            if (sensorInput[phase_q] && (ext_cnt_q < ExtW'(MAX_EXT))) begin
              state_d   = StGrnExt;
              remain_d  = nz(ext_t_q);
              ext_cnt_d = ext_cnt_q + ExtW'(1);
            end else begin
              state_d  = StYel;
              remain_d = nz(yel_t_q);
            end
          end
          StYel: begin
            if ((phase_q == PhW'(WALK_PH)) && pend_q) begin
              state_d  = StWalk;
              remain_d = nz(CNT_W'(WALK_T));
              // Entering walk serves the request, including one arriving this cycle.
              pend_d   = 1'b0;
            end else begin
              state_d  = StAllRed;
              remain_d = nz(CNT_W'(ALLRED_T));
            end
          end
          StWalk: begin
            state_d  = StAllRed;
            remain_d = nz(CNT_W'(ALLRED_T));
          end
          StAllRed: begin
            state_d   = StGrnBase;
            phase_d   = (phase_q == PhW'(N_PHASES - 1)) ? '0 : phase_q + PhW'(1);
            remain_d  = nz(base_t_q);
            ext_cnt_d = '0;
          end
          default: begin
            state_d   = StGrnBase;
            phase_d   = '0;
            remain_d  = nz(base_t_q);
            ext_cnt_d = '0;
          end
        endcase
      end else begin
        remain_d = remain_q - CNT_W'(1);
      end
    end
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    if ((state_d == StGrnBase) || (state_d == StGrnExt)) begin
      green_d = N_PHASES'(1) << phase_d;
    end
    if (state_d == StYel) begin
      yellow_d = N_PHASES'(1) << phase_d;
    end
    red_d  = ~(green_d | yellow_d);
    walk_d = (state_d == StWalk);
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      state_q   <= StGrnBase;
      phase_q   <= '0;
      remain_q  <= nz(CNT_W'(BASE_T));
      ext_cnt_q <= '0;
      base_t_q  <= CNT_W'(BASE_T);
      ext_t_q   <= CNT_W'(EXT_T);
      yel_t_q   <= CNT_W'(YEL_T);
      pend_q    <= 1'b0;
      green_q   <= N_PHASES'(1);
      yellow_q  <= '0;
      red_q     <= ~N_PHASES'(1);
      walk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      ext_cnt_q <= ext_cnt_d;
      base_t_q  <= base_t_d;
      ext_t_q   <= ext_t_d;
      yel_t_q   <= yel_t_d;
      pend_q    <= pend_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
      walk_q    <= walk_d;
    end
  end

  assign greenOut    = green_q;
  assign yellowOut   = yellow_q;
  assign redOut      = red_q;
  assign walkOut     = walk_q;
  assign walkPending = pend_q;
  assign phaseIdx    = phase_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: a 2-phase and a 3-phase instance share stimulus and are
// compared every cycle against an elapsed-tick interval model, plus literal sequence checks.
module tb_traffic_phase_sequencer;

  localparam int K_G = 0;
  localparam int K_Y = 1;
  localparam int K_R = 2;
  localparam int K_W = 3;

  logic       clk = 1'b0;
  logic       globalReset = 1'b1;
  logic       tick = 1'b0;
  logic       reprogramInp = 1'b0;
  logic [7:0] baseTime = 8'd0;
  logic [7:0] extTime = 8'd0;
  logic [7:0] yelTime = 8'd0;
  logic [1:0] sens2 = 2'b00;
  logic [2:0] sens3;
  logic       walkReq = 1'b0;

  logic [1:0] green2, yellow2, red2;
  logic       walk2, pend2;
  logic [0:0] phase2;
  logic [2:0] green3, yellow3, red3;
  logic       walk3, pend3;
  logic [1:0] phase3;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  assign sens3 = {1'b0, sens2};

  always #5 clk = ~clk;

  traffic_phase_sequencer dut2 (
    .clk(clk), .globalReset(globalReset), .tick(tick), .reprogramInp(reprogramInp),
    .baseTime(baseTime), .extTime(extTime), .yelTime(yelTime), .sensorInput(sens2),
    .walkReq(walkReq), .greenOut(green2), .yellowOut(yellow2), .redOut(red2),
    .walkOut(walk2), .walkPending(pend2), .phaseIdx(phase2)
  );

  traffic_phase_sequencer #(.N_PHASES(3)) dut3 (
    .clk(clk), .globalReset(globalReset), .tick(tick), .reprogramInp(reprogramInp),
    .baseTime(baseTime), .extTime(extTime), .yelTime(yelTime), .sensorInput(sens3),
    .walkReq(walkReq), .greenOut(green3), .yellowOut(yellow3), .redOut(red3),
    .walkOut(walk3), .walkPending(pend3), .phaseIdx(phase3)
  );

  // Model: each interval has a kind, a length and a count of ticks already spent in it.
  int m_kind[2], m_phase[2], m_el[2], m_lim[2], m_ext[2], m_pend[2];
  int m_base[2], m_extt[2], m_yel[2];

  function automatic int nph(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int atleast1(int t);
    return (t == 0) ? 1 : t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = K_G; m_phase[i] = 0; m_el[i] = 0; m_lim[i] = 6; m_ext[i] = 0;
      m_pend[i] = 0; m_base[i] = 6; m_extt[i] = 3; m_yel[i] = 2;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int s;
      int served;
      s = (i == 0) ? int'(sens2) : int'(sens3);
      served = 0;
      if (reprogramInp) begin
        m_base[i] = int'(baseTime); m_extt[i] = int'(extTime); m_yel[i] = int'(yelTime);
        m_kind[i] = K_G; m_phase[i] = 0; m_el[i] = 0; m_ext[i] = 0;
        m_lim[i] = atleast1(m_base[i]);
      end else if (tick) begin
        m_el[i]++;
        if (m_el[i] >= m_lim[i]) begin
          m_el[i] = 0;
          case (m_kind[i])
            K_G: begin
              if (((s >> m_phase[i]) & 1) == 1 && m_ext[i] < 2) begin
                m_ext[i]++;
                m_lim[i] = atleast1(m_extt[i]);
              end else begin
                m_kind[i] = K_Y;
                m_lim[i] = atleast1(m_yel[i]);
              end
            end
            K_Y: begin
              if (m_phase[i] == 0 && m_pend[i] == 1) begin
                m_kind[i] = K_W; m_lim[i] = 4; served = 1;
              end else begin
                m_kind[i] = K_R; m_lim[i] = 1;
              end
            end
            K_W: begin
              m_kind[i] = K_R; m_lim[i] = 1;
            end
            default: begin
              m_kind[i] = K_G;
              m_phase[i] = (m_phase[i] + 1) % nph(i);
              m_ext[i] = 0;
              m_lim[i] = atleast1(m_base[i]);
            end
          endcase
        end
      end
      m_pend[i] = served ? 0 : (m_pend[i] | int'(walkReq));
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge globalReset);
      if (globalReset) model_reset();
      else model_step();
    end
  end

  function automatic int e_green(int i);
    return (m_kind[i] == K_G) ? (1 << m_phase[i]) : 0;
  endfunction

  function automatic int e_yel(int i);
    return (m_kind[i] == K_Y) ? (1 << m_phase[i]) : 0;
  endfunction

  function automatic int e_red(int i);
    return ((1 << nph(i)) - 1) & ~(e_green(i) | e_yel(i));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !globalReset) begin
      chk("d2_green", int'(green2), e_green(0));
      chk("d2_yellow", int'(yellow2), e_yel(0));
      chk("d2_red", int'(red2), e_red(0));
      chk("d2_walk", int'(walk2), int'(m_kind[0] == K_W));
      chk("d2_pend", int'(pend2), m_pend[0]);
      chk("d2_phase", int'(phase2), m_phase[0]);
      chk("d3_green", int'(green3), e_green(1));
      chk("d3_yellow", int'(yellow3), e_yel(1));
      chk("d3_red", int'(red3), e_red(1));
      chk("d3_walk", int'(walk3), int'(m_kind[1] == K_W));
      chk("d3_pend", int'(pend3), m_pend[1]);
      chk("d3_phase", int'(phase3), m_phase[1]);
      chk("d2_onehot", int'($onehot0(green2 | yellow2) && ((green2 & yellow2) == 2'b00)), 1);
      chk("d3_onehot", int'($onehot0(green3 | yellow3) && ((green3 & yellow3) == 3'b000)), 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick every fourth clock; returns just after the edge that consumed the tick.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(); cyc(); cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  initial begin
    cyc(); cyc();
    globalReset = 1'b0;
    chk_en = 1'b1;
    chk("rst_green", int'(green2), 1);
    chk("rst_yellow", int'(yellow2), 0);
    chk("rst_red", int'(red2), 2);
    chk("rst_walk", int'(walk2), 0);

    // Default sequence, no sensors.
    tick_n(5);
    chk("t1_green0_held", int'(green2), 1);
    tick_n(1);
    chk("t1_yellow0", int'(yellow2), 1);
    tick_n(2);
    chk("t1_allred", int'(red2), 3);
    tick_n(1);
    chk("t1_green1", int'(green2), 2);
    tick_n(9);
    chk("t1_green0_again", int'(green2), 1);

    // Held sensor: two extensions then yellow regardless.
    sens2 = 2'b01;
    tick_n(11);
    chk("t2_green0_ext", int'(green2), 1);
    tick_n(1);
    chk("t2_yellow0", int'(yellow2), 1);
    sens2 = 2'b00;
    tick_n(3);
    chk("t2_green1", int'(green2), 2);

    // Walk request during green[1] is served after yellow[0].
    cyc();
    walkReq = 1'b1;
    cyc();
    walkReq = 1'b0;
    chk("t3_pend_set", int'(pend2), 1);
    tick_n(15);
    chk("t3_yellow0", int'(yellow2), 1);
    chk("t3_pend_held", int'(pend2), 1);
    tick_n(2);
    chk("t3_walk_on", int'(walk2), 1);
    chk("t3_walk_red", int'(red2), 3);
    chk("t3_pend_clr", int'(pend2), 0);
    tick_n(4);
    chk("t3_walk_off", int'(walk2), 0);
    chk("t3_allred", int'(red2), 3);
    tick_n(1);
    chk("t3_green1", int'(green2), 2);

    // Reprogram during yellow[1], with a tick in the same cycle.
    tick_n(6);
    chk("t4_yellow1", int'(yellow2), 2);
    cyc(); cyc();
    baseTime = 8'd10; extTime = 8'd3; yelTime = 8'd0;
    reprogramInp = 1'b1;
    tick = 1'b1;
    cyc();
    reprogramInp = 1'b0;
    tick = 1'b0;
    chk("t4_green0", int'(green2), 1);
    chk("t4_phase0", int'(phase2), 0);
    tick_n(9);
    chk("t4_green0_held", int'(green2), 1);
    tick_n(1);
    chk("t4_yellow0", int'(yellow2), 1);
    tick_n(1);
    chk("t4_yel_one_tick", int'(red2), 3);
    tick_n(1);
    chk("t4_green1", int'(green2), 2);

    // Asynchronous reset in the middle of a walk interval.
    cyc();
    walkReq = 1'b1;
    cyc();
    walkReq = 1'b0;
    tick_n(12);
    chk("t5_green0", int'(green2), 1);
    tick_n(10);
    chk("t5_yellow0", int'(yellow2), 1);
    tick_n(1);
    chk("t5_walk", int'(walk2), 1);
    cyc();
    #1;
    globalReset = 1'b1;
    #1;
    chk("t5_rst_green", int'(green2), 1);
    chk("t5_rst_walk", int'(walk2), 0);
    chk("t5_rst_pend", int'(pend2), 0);
    chk("t5_rst_red", int'(red2), 2);
    chk("t5_rst_green3", int'(green3), 1);
    #1;
    globalReset = 1'b0;
    tick_n(6);
    chk("t5_default_base", int'(yellow2), 1);

    // Three-phase rotation on the second instance.
    tick_n(3);
    chk("t6_d3_green1", int'(green3), 2);
    tick_n(9);
    chk("t6_d3_green2", int'(green3), 4);
    chk("t6_d3_phase2", int'(phase3), 2);
    tick_n(9);
    chk("t6_d3_green0", int'(green3), 1);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
